mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Execute-stage multiply/divide scheduler with HI/LO register file for the 5-stage MIPS pipeline (P7).
- Accepts mult/multu/div/divu/mthi/mtlo from E and sequences multi-cycle operations with a counter-driven FSM.
- Commits results to HI/LO and drives the D-stage stall for HI/LO-class instructions flagged by the decoder's Stop_D.
- Honours the exception/interrupt request so that a flushed E-stage instruction never starts or writes HI/LO.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- md_start  in  1  E-stage instruction is a valid HI/LO-class op this cycle
- md_op  in  3  operation code (package constants)
- src_a  in  32  forwarded rs value
- src_b  in  32  forwarded rt value
- req  in  1  exception/interrupt flush of the E-stage instruction
- stop_d  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo (decoder Stop_D)
- busy  out  1  multi-cycle operation in progress (registered)
- stall_md  out  1  stall request for F/D (combinational)
- done  out  1  one-cycle pulse after a HI/LO commit from mult/div
- hi  out  32  current HI
- lo  out  32  current LO

Behaviour:
- Reset: asynchronous. State IDLE, counter 0, busy=0, done=0, hi=0, lo=0, result temporaries=0.
- Accept: acc = md_start & ~req & (state==IDLE).
  - md_start while not IDLE is ignored; the pipeline guarantees this never happens.
  - md_op==MD_NONE is a no-op.
- FSM states:
  - IDLE
    - acc with MULT/MULTU -> MUL_RUN, counter := MUL_CYCLES.
    - acc with DIV/DIVU -> DIV_RUN, counter := DIV_CYCLES.
    - acc with MTHI -> hi := src_a on the same edge, stays IDLE.
    - acc with MTLO -> lo := src_a on the same edge, stays IDLE.
  - MUL_RUN / DIV_RUN
    - Counter decrements each cycle.
    - On the edge where counter==1: commit temporaries to hi/lo, -> IDLE, done=1 for the following cycle.
- Operands and results: captured into temporaries on the accept edge. Later changes to src_a/src_b have no effect.
- Busy timing: busy=1 for exactly N cycles following the accept edge (N = MUL_CYCLES or DIV_CYCLES). hi/lo show old values until the commit edge.
- Arithmetic:
  - mult: signed 32x32 -> 64, hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 -> 64, same split.
  - div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned; lo = quotient, hi = remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div/divu): runs the full DIV_CYCLES with busy asserted, but HI/LO are left unchanged; done still pulses.
- Stall: stall_md = stop_d & (busy | (acc & md_op in {MULT, MULTU, DIV, DIVU})).
  - mfhi/mflo in D during the cycle of a mult/div accept stall.
  - mthi/mtlo accepted in E does not stall D; D-stage mfhi then reads the updated hi on the next cycle.
- req:
  - req in the same cycle as md_start: nothing starts and nothing is written.
  - req while busy: the running operation continues and commits. It belongs to an older, already-committed instruction.
- Reset mid-operation: returns to IDLE immediately, hi/lo=0, no commit.

Decomposition:
- Shared head.v constants:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6
  - state encodings S_IDLE=0, S_MUL=1, S_DIV=2
- One sub-module, mdu_alu: purely combinational, computes the {hi, lo} result from op/a/b including the special cases. mdu_ctrl holds the FSM, counter, temporaries and HI/LO.

Test Plan:
- mult: src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div, dividend/divisor cases (busy 10 cycles each):
  - -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0
  - divu 7/0 -> hi/lo unchanged after 10 cycles
- Stall: accept mult with stop_d=1 (mflo in D) -> stall_md=1 from the accept cycle through the 5 busy cycles, low on the cycle after commit. stop_d=0 -> stall_md=0 throughout.
- md_start=1, md_op=MD_MULT, req=1 -> busy stays 0, hi/lo unchanged. Then mtlo src_a=0x1234 with req=1 -> lo unchanged; with req=0 -> lo=0x1234 next cycle.
- Assert reset at the 3rd cycle of div -> busy=0, hi=lo=0 immediately (asynchronous). A new mult after release completes normally.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared HI/LO unit definitions: operation codes and controller state encodings.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide datapath producing the HI/LO result for one op.
module mdu_alu
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_nz;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;

  always_comb begin
    prod_s = signed'({{32{a[31]}}, a}) * signed'({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
    // Divisor forced non-zero so the dividers never see 0; the write is suppressed instead.
    b_nz   = (b == '0) ? 32'd1 : b;
    // Signed divide via magnitudes: 0x80000000/-1 falls out as lo=0x80000000, hi=0.
    a_mag  = a[31] ? -a : a;
    b_mag  = b_nz[31] ? -b_nz : b_nz;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;

    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      MD_DIV: begin
        res_lo = (a[31] ^ b[31]) ? -q_mag : q_mag;
        res_hi = a[31] ? -r_mag : r_mag;
        res_wr = (b != '0);
      end
      MD_DIVU: begin
        res_lo = a / b_nz;
        res_hi = a % b_nz;
        res_wr = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage multiply/divide scheduler: counter-driven FSM, operand-result
// temporaries and the architectural HI/LO registers, plus the D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req,
  input  logic        stop_d,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      tmp_hi;
  logic [31:0]      tmp_lo;
  logic             tmp_wr;
  logic [31:0]      alu_hi;
  logic [31:0]      alu_lo;
  logic             alu_wr;
  logic             acc;

  mdu_alu u_alu (
    .op     (md_op),
    .a      (src_a),
    .b      (src_b),
    .res_hi (alu_hi),
    .res_lo (alu_lo),
    .res_wr (alu_wr)
  );

  assign acc      = md_start & ~req & (state == S_IDLE);
  assign stall_md = stop_d & (busy | (acc & is_long_op(md_op)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      tmp_hi  <= '0;
      tmp_lo  <= '0;
      tmp_wr  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                state   <= S_MUL;
                counter <= CNT_W'(MUL_CYCLES);
                busy    <= 1'b1;
                tmp_hi  <= alu_hi;
                tmp_lo  <= alu_lo;
                tmp_wr  <= alu_wr;
              end
              MD_DIV, MD_DIVU: begin
                state   <= S_DIV;
                counter <= CNT_W'(DIV_CYCLES);
                busy    <= 1'b1;
                tmp_hi  <= alu_hi;
                tmp_lo  <= alu_lo;
                tmp_wr  <= alu_wr;
              end
              MD_MTHI: hi <= src_a;
              MD_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (counter == CNT_W'(1)) begin
            if (tmp_wr) begin
              hi <= tmp_hi;
              lo <= tmp_lo;
            end
            state   <= S_IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO queued at issue, checked at the done pulse.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req;
  logic        stop_d;
  logic        busy;
  logic        stall_md;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .req      (req),
    .stop_d   (stop_d),
    .busy     (busy),
    .stall_md (stall_md),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] old);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = old;
    case (op)
      MD_MULT:  p = sa * sb;
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      MD_DIVU:  if (b != 0) p = {a % b, a / b};
      default:  p = old;
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input int unsigned n, input logic stop,
                        input logic req_mid, input string name);
    int unsigned nb;
    int unsigned guard;
    logic [63:0] exp_pop;
    md_start = 1'b1; md_op = op; src_a = a; src_b = b; stop_d = stop; req = 1'b0;
    #1;
    checks++; if (stall_md !== stop) begin errors++; $display("FAIL %s_accept_stall got %b want %b", name, stall_md, stop); end
    sb_q.push_back(expv);
    tick();
    md_start = 1'b0; md_op = MD_NONE; src_a = $urandom; src_b = $urandom; req = req_mid;
    nb = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      if (busy === 1'b1) nb++;
      checks++; if ({hi, lo} !== {cur_hi, cur_lo}) begin errors++; $display("FAIL %s_hold got %h want %h", name, {hi, lo}, {cur_hi, cur_lo}); end
      checks++; if (stall_md !== stop) begin errors++; $display("FAIL %s_busy_stall got %b want %b", name, stall_md, stop); end
      tick();
      guard++;
    end
    req = 1'b0;
    checks++; if (guard >= 200) begin errors++; $display("FAIL %s_done_timeout got %0d want <200", name, guard); end
    checks++; if (nb !== n) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, nb, n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b want 0", name, busy); end
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL %s_stall_after got %b want 0", name, stall_md); end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s_scoreboard_empty got 0 want 1", name);
    end else begin
      exp_pop = sb_q.pop_front();
      if ({hi, lo} !== exp_pop) begin errors++; $display("FAIL %s_result got %h want %h", name, {hi, lo}, exp_pop); end
      cur_hi = exp_pop[63:32];
      cur_lo = exp_pop[31:0];
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_reset();
    reset = 1'b1; md_start = 1'b0; md_op = MD_NONE; src_a = '0; src_b = '0; req = 1'b0; stop_d = 1'b1;
    tick();
    tick();
    #1;
    checks++; if ({busy, done, stall_md} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {busy, done, stall_md}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    reset = 1'b0;
    stop_d = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5, 1'b1, 1'b0, "mult");
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 5, 1'b0, 1'b0, "multu");
  endtask

  task automatic test_div();
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b1, 1'b0, "div_neg");
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 1'b0, 1'b0, "div_ovf");
    run_op(MD_DIVU, 32'd7, 32'd0, {cur_hi, cur_lo}, 10, 1'b0, 1'b0, "divu_zero");
    run_op(MD_DIV, 32'd9, 32'd0, {cur_hi, cur_lo}, 10, 1'b1, 1'b0, "div_zero");
  endtask

  task automatic test_req();
    md_start = 1'b1; md_op = MD_MULT; src_a = 32'd11; src_b = 32'd13; req = 1'b1; stop_d = 1'b1;
    #1;
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL req_mult_stall got %b want 0", stall_md); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_mult_busy got %b want 0", busy); end
    checks++; if ({hi, lo} !== {cur_hi, cur_lo}) begin errors++; $display("FAIL req_mult_hilo got %h want %h", {hi, lo}, {cur_hi, cur_lo}); end
    md_op = MD_MTLO; src_a = 32'h1234; req = 1'b1;
    tick();
    checks++; if (lo !== cur_lo) begin errors++; $display("FAIL req_mtlo_lo got %h want %h", lo, cur_lo); end
    req = 1'b0;
    #1;
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL mtlo_stall got %b want 0", stall_md); end
    tick();
    cur_lo = 32'h1234;
    checks++; if (lo !== cur_lo) begin errors++; $display("FAIL mtlo_lo got %h want %h", lo, cur_lo); end
    md_op = MD_MTHI; src_a = 32'hCAFE_F00D;
    tick();
    cur_hi = 32'hCAFE_F00D;
    checks++; if (hi !== cur_hi) begin errors++; $display("FAIL mthi_hi got %h want %h", hi, cur_hi); end
    md_start = 1'b0; md_op = MD_NONE; stop_d = 1'b0;
    run_op(MD_MULTU, 32'h10, 32'h20, 64'h00000000_00000200, 5, 1'b1, 1'b1, "req_while_busy");
  endtask

  task automatic test_reset_mid();
    md_start = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7; req = 1'b0; stop_d = 1'b0;
    tick();
    md_start = 1'b0; md_op = MD_NONE;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo got %h want 0", {hi, lo}); end
    tick();
    reset = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (12) tick();
    checks++; if ({hi, lo, done} !== 65'h0) begin errors++; $display("FAIL rst_mid_nocommit got %h want 0", {hi, lo, done}); end
    run_op(MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 5, 1'b0, 1'b0, "mult_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'(MD_MULT + $urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(op, a, b, model(op, a, b, {cur_hi, cur_lo}),
             (op == MD_MULT || op == MD_MULTU) ? 5 : 10, 1'(i % 2), 1'b0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_req();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
